// File: rtl/candy_wb_queue_if.sv
// Upstream offer, register-file write and bypass lookup signals of the
// write-back queue. The queue attaches through the slave modport.
interface candy_wb_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [3:0]    in_addr;
  logic [23:0]   in_data;
  logic          in_ready;
  logic          hold;
  logic          we;
  logic [3:0]    waddr;
  logic [23:0]   wdata;
  logic [3:0]    raddr1;
  logic [3:0]    raddr2;
  logic          hit1;
  logic          hit2;
  logic [23:0]   byp1;
  logic [23:0]   byp2;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_addr, in_data, hold, raddr1, raddr2,
    output in_ready, we, waddr, wdata, hit1, hit2, byp1, byp2, count
  );

  modport master (
    output in_valid, in_addr, in_data, hold, raddr1, raddr2,
    input  in_ready, we, waddr, wdata, hit1, hit2, byp1, byp2, count
  );
endinterface

// File: rtl/candy_wb_queue.sv
// Register write-back queue: FIFO of pending writes drained into the register
// file, with youngest-match bypass lookup for two read ports.
module candy_wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  candy_wb_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    addr_q [DEPTH];
  logic [23:0]   data_q [DEPTH];

  logic occupied;
  logic accept;
  logic pop;

  assign occupied = (count_q != '0);
  assign accept   = bus.in_valid && (count_q < CW'(DEPTH));
  assign pop      = occupied && !bus.hold;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[wr_ptr_q] <= bus.in_addr;
      data_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.in_ready = (count_q < CW'(DEPTH));
  assign bus.we       = pop;
  assign bus.waddr    = occupied ? addr_q[rd_ptr_q] : 4'h0;
  assign bus.wdata    = occupied ? data_q[rd_ptr_q] : 24'h0;
  assign bus.count    = count_q;

  // Walk oldest to youngest so the last match is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    bus.hit1 = 1'b0;
    bus.hit2 = 1'b0;
    bus.byp1 = 24'h0;
    bus.byp2 = 24'h0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (addr_q[idx] == bus.raddr1) begin
          bus.hit1 = 1'b1;
          bus.byp1 = data_q[idx];
        end
        if (addr_q[idx] == bus.raddr2) begin
          bus.hit2 = 1'b1;
          bus.byp2 = data_q[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_candy_wb_queue.sv
// Directed bench for candy_wb_queue: vector table plus hand-written
// streaming and reset-mid-drain sequences.
module tb_candy_wb_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  candy_wb_queue_if #(.DEPTH(DEPTH)) bus ();

  candy_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  a;
    logic [23:0] d;
    logic        h;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic        e_rdy;
    logic        e_we;
    logic [3:0]  e_wa;
    logic [23:0] e_wd;
    logic [CW-1:0] e_cnt;
    logic        e_h1;
    logic [23:0] e_b1;
    logic        e_h2;
    logic [23:0] e_b2;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [23:0] d, input logic h);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.hold     = h;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // in, addr, data, hold, raddr1, raddr2 | rdy, we, waddr, wdata, count, hit1, byp1, hit2, byp2
    vecs[0]  = '{1'b1, 4'h1, 24'h124b36, 1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 4'h0, 24'h0,      3'd0, 1'b0, 24'h0,      1'b0, 24'h0};
    vecs[1]  = '{1'b0, 4'h0, 24'h0,      1'b0, 4'h1, 4'h0, 1'b1, 1'b1, 4'h1, 24'h124b36, 3'd1, 1'b1, 24'h124b36, 1'b0, 24'h0};
    vecs[2]  = '{1'b0, 4'h0, 24'h0,      1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 4'h0, 24'h0,      3'd0, 1'b0, 24'h0,      1'b0, 24'h0};
    vecs[3]  = '{1'b1, 4'h1, 24'h124b36, 1'b1, 4'h5, 4'h1, 1'b1, 1'b0, 4'h0, 24'h0,      3'd0, 1'b0, 24'h0,      1'b0, 24'h0};
    vecs[4]  = '{1'b1, 4'h2, 24'h655356, 1'b1, 4'h5, 4'h1, 1'b1, 1'b0, 4'h1, 24'h124b36, 3'd1, 1'b0, 24'h0,      1'b1, 24'h124b36};
    vecs[5]  = '{1'b1, 4'h3, 24'h5a0024, 1'b1, 4'h5, 4'h1, 1'b1, 1'b0, 4'h1, 24'h124b36, 3'd2, 1'b0, 24'h0,      1'b1, 24'h124b36};
    vecs[6]  = '{1'b1, 4'h4, 24'h5a0034, 1'b1, 4'h5, 4'h1, 1'b1, 1'b0, 4'h1, 24'h124b36, 3'd3, 1'b0, 24'h0,      1'b1, 24'h124b36};
    vecs[7]  = '{1'b1, 4'h5, 24'h000001, 1'b1, 4'h5, 4'h1, 1'b0, 1'b0, 4'h1, 24'h124b36, 3'd4, 1'b0, 24'h0,      1'b1, 24'h124b36};
    vecs[8]  = '{1'b1, 4'h5, 24'h000001, 1'b0, 4'h5, 4'h1, 1'b0, 1'b1, 4'h1, 24'h124b36, 3'd4, 1'b0, 24'h0,      1'b1, 24'h124b36};
    vecs[9]  = '{1'b1, 4'h5, 24'h000001, 1'b0, 4'h5, 4'h1, 1'b1, 1'b1, 4'h2, 24'h655356, 3'd3, 1'b0, 24'h0,      1'b0, 24'h0};
    vecs[10] = '{1'b0, 4'h0, 24'h0,      1'b0, 4'h5, 4'h1, 1'b1, 1'b1, 4'h3, 24'h5a0024, 3'd3, 1'b1, 24'h000001, 1'b0, 24'h0};
    vecs[11] = '{1'b0, 4'h0, 24'h0,      1'b0, 4'h5, 4'h1, 1'b1, 1'b1, 4'h4, 24'h5a0034, 3'd2, 1'b1, 24'h000001, 1'b0, 24'h0};
    vecs[12] = '{1'b0, 4'h0, 24'h0,      1'b0, 4'h5, 4'h1, 1'b1, 1'b1, 4'h5, 24'h000001, 3'd1, 1'b1, 24'h000001, 1'b0, 24'h0};
    vecs[13] = '{1'b0, 4'h0, 24'h0,      1'b0, 4'h5, 4'h1, 1'b1, 1'b0, 4'h0, 24'h0,      3'd0, 1'b0, 24'h0,      1'b0, 24'h0};
    vecs[14] = '{1'b1, 4'h3, 24'h5a0024, 1'b1, 4'h3, 4'h4, 1'b1, 1'b0, 4'h0, 24'h0,      3'd0, 1'b0, 24'h0,      1'b0, 24'h0};
    vecs[15] = '{1'b1, 4'h3, 24'h000abc, 1'b1, 4'h3, 4'h4, 1'b1, 1'b0, 4'h3, 24'h5a0024, 3'd1, 1'b1, 24'h5a0024, 1'b0, 24'h0};
    vecs[16] = '{1'b0, 4'h0, 24'h0,      1'b1, 4'h3, 4'h4, 1'b1, 1'b0, 4'h3, 24'h5a0024, 3'd2, 1'b1, 24'h000abc, 1'b0, 24'h0};
    vecs[17] = '{1'b0, 4'h0, 24'h0,      1'b0, 4'h3, 4'h4, 1'b1, 1'b1, 4'h3, 24'h5a0024, 3'd2, 1'b1, 24'h000abc, 1'b0, 24'h0};
    vecs[18] = '{1'b0, 4'h0, 24'h0,      1'b0, 4'h3, 4'h4, 1'b1, 1'b1, 4'h3, 24'h000abc, 3'd1, 1'b1, 24'h000abc, 1'b0, 24'h0};
    vecs[19] = '{1'b1, 4'h0, 24'habcdef, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 24'h0,      3'd0, 1'b0, 24'h0,      1'b0, 24'h0};
    vecs[20] = '{1'b0, 4'h0, 24'h0,      1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 24'habcdef, 3'd1, 1'b1, 24'habcdef, 1'b1, 24'habcdef};
    vecs[21] = '{1'b0, 4'h7, 24'hffffff, 1'b0, 4'h7, 4'h0, 1'b1, 1'b0, 4'h0, 24'h0,      3'd0, 1'b0, 24'h0,      1'b0, 24'h0};
    vecs[22] = '{1'b0, 4'h7, 24'hffffff, 1'b0, 4'h7, 4'h0, 1'b1, 1'b0, 4'h0, 24'h0,      3'd0, 1'b0, 24'h0,      1'b0, 24'h0};

    rst = 1'b0;
    drive(1'b0, 4'h0, 24'h0, 1'b0);
    bus.raddr1 = 4'h0;
    bus.raddr2 = 4'h0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_we",       32'(bus.we),       32'd0);
    chk("rst_count",    32'(bus.count),    32'd0);
    chk("rst_waddr",    32'(bus.waddr),    32'd0);
    chk("rst_hit1",     32'(bus.hit1),     32'd0);
    rst = 1'b1;
    step();

    // Vector table: inputs applied, outputs checked before the next edge.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].h);
      bus.raddr1 = vecs[i].r1;
      bus.raddr2 = vecs[i].r2;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_we", i),       32'(bus.we),       32'(vecs[i].e_we));
      chk($sformatf("v%0d_waddr", i),    32'(bus.waddr),    32'(vecs[i].e_wa));
      chk($sformatf("v%0d_wdata", i),    32'(bus.wdata),    32'(vecs[i].e_wd));
      chk($sformatf("v%0d_count", i),    32'(bus.count),    32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_hit1", i),     32'(bus.hit1),     32'(vecs[i].e_h1));
      chk($sformatf("v%0d_byp1", i),     32'(bus.byp1),     32'(vecs[i].e_b1));
      chk($sformatf("v%0d_hit2", i),     32'(bus.hit2),     32'(vecs[i].e_h2));
      chk($sformatf("v%0d_byp2", i),     32'(bus.byp2),     32'(vecs[i].e_b2));
      step();
    end

    // Streaming: one offer per cycle, each written the cycle after.
    bus.raddr1 = 4'hf;
    bus.raddr2 = 4'hf;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 4'(k), 24'h100000 + 24'(k), 1'b0);
      #1;
      if (k == 0) begin
        chk("stream_count0", 32'(bus.count), 32'd0);
      end else begin
        chk($sformatf("stream%0d_count", k), 32'(bus.count), 32'd1);
        chk($sformatf("stream%0d_we", k),    32'(bus.we),    32'd1);
        chk($sformatf("stream%0d_waddr", k), 32'(bus.waddr), 32'(k - 1));
        chk($sformatf("stream%0d_wdata", k), 32'(bus.wdata), 32'h100000 + 32'(k - 1));
      end
      step();
    end
    drive(1'b0, 4'h0, 24'h0, 1'b0);
    #1;
    chk("stream_last_waddr", 32'(bus.waddr), 32'd9);
    chk("stream_last_wdata", 32'(bus.wdata), 32'h100009);
    chk("stream_last_we",    32'(bus.we),    32'd1);
    step();
    chk("stream_empty", 32'(bus.count), 32'd0);

    // Reset mid-drain.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'(k + 8), 24'h200000 + 24'(k), 1'b1);
      step();
    end
    drive(1'b0, 4'h0, 24'h0, 1'b0);
    bus.raddr1 = 4'h9;
    #1;
    chk("rmd_count3", 32'(bus.count), 32'd3);
    chk("rmd_we",     32'(bus.we),    32'd1);
    step();
    chk("rmd_count2", 32'(bus.count), 32'd2);
    chk("rmd_hit_pre", 32'(bus.hit1), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rmd_rst_we",    32'(bus.we),       32'd0);
    chk("rmd_rst_count", 32'(bus.count),    32'd0);
    chk("rmd_rst_hit1",  32'(bus.hit1),     32'd0);
    chk("rmd_rst_byp1",  32'(bus.byp1),     32'd0);
    chk("rmd_rst_waddr", 32'(bus.waddr),    32'd0);
    chk("rmd_rst_rdy",   32'(bus.in_ready), 32'd1);
    step();
    chk("rmd_edge_we",    32'(bus.we),    32'd0);
    chk("rmd_edge_count", 32'(bus.count), 32'd0);
    #2;
    rst = 1'b1;
    drive(1'b1, 4'h2, 24'h655356, 1'b0);
    #1;
    chk("rmd_post_count0", 32'(bus.count), 32'd0);
    step();
    drive(1'b0, 4'h0, 24'h0, 1'b0);
    #1;
    chk("rmd_post_we",    32'(bus.we),    32'd1);
    chk("rmd_post_waddr", 32'(bus.waddr), 32'd2);
    chk("rmd_post_wdata", 32'(bus.wdata), 32'h655356);
    step();
    chk("rmd_post_empty", 32'(bus.count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
